io_hub: RTL and testbench
=========================

Name: io_hub

Overview:
- Parametrised memory-mapped I/O controller for the single-cycle CPU.
- Replaces the fixed switch/LED/segment/two-button handling with configurable widths, N debounced buttons, sticky edge-event flags with write-1-to-clear, and a programmable blink generator.
- Sits between the CPU's IORead/IOWrite path and the board pins; feeds the display driver.

Parameters:
- NUM_BTN, 4, number of button channels (1..8).
- SW_W, 24, switch input width (1..32).
- LED_W, 24, LED register width (1..32).
- SEG_W, 32, seven-segment data register width (4 bits per digit).
- DEB_CYCLES, 200000, consecutive stable cycles required to accept a button level change (>=2).
- BLINK_W, 24, blink divider counter width.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- io_rd  in  1  CPU I/O read strobe.
- io_wr  in  1  CPU I/O write strobe; one write per asserted cycle.
- io_addr  in  5  byte offset within the I/O window; bits [1:0] ignored.
- io_wdata  in  32  write data.
- io_rdata  out  32  read data; combinational from registered state; 0 when io_rd=0.
- switch  in  SW_W  raw switches.
- button  in  NUM_BTN  raw buttons, active-high.
- led_out  out  LED_W  LED drive.
- seg_data  out  SEG_W  segment data to the display driver.
- blink_out  out  1  blink phase.
- irq  out  1  event interrupt (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, synchronisers, debounce counters, event flags, blink counter and blink_out clear to 0.
  - led_out=0, seg_data=0, irq=0.
- Switch path: 2-flop synchroniser; SW reads the second stage (2-cycle latency); upper bits zero-extended.
- Button path, per channel:
  - 2-flop synchroniser, then a counter.
  - While the synced input differs from the debounced level, the counter increments; it clears on any cycle where they are equal.
  - When the counter reaches DEB_CYCLES-1 while still differing, the level flips and the counter clears.
  - A glitch shorter than DEB_CYCLES never changes the level.
  - Total latency from a clean edge is DEB_CYCLES+2 cycles.
- Event flags:
  - A 0->1 transition of the debounced level sets event[i] on the same edge the level flips.
  - A write to EVENT with bit i=1 clears event[i].
  - If set and clear occur in the same cycle, set wins.
- Register map (io_addr):
  - 0x00 SW, RO.
  - 0x04 BTN_LEVEL, RO.
  - 0x08 BTN_EVENT, RO with W1C.
  - 0x0C LED, RW, width LED_W.
  - 0x10 SEG, RW, width SEG_W.
  - 0x14 BLINK_CTRL, RW: bit0 enable, bits[BLINK_W:1] half-period.
  - 0x18 IRQ_MASK, RW, width NUM_BTN.
  - Unmapped offsets read 0; writes to them or to RO registers are ignored.
  - Unused upper bits read 0.
- Writes take effect at the posedge where io_wr=1. A same-cycle read returns the old value.
- Blink:
  - With enable=1 and half-period P>0, a counter counts 0..P-1; at P-1 it wraps to 0 and toggles blink_out.
  - With enable=0 or P=0, the counter holds at 0 and blink_out=0.
  - A write to BLINK_CTRL clears the counter; blink_out keeps its value unless the new enable=0.
- LED output: led_out = LED & ~(blink_mask), where blink_mask = all ones when enable=1 and blink_out=0, else 0. Net effect: all LEDs flash together when blinking.

Optional Feature:
- Macro IO_HUB_IRQ_EN.
- Defined:
  - irq is registered, = |(BTN_EVENT & IRQ_MASK), one cycle after the flags update.
  - IRQ_MASK is RW.
- Undefined:
  - irq is tied 0.
  - IRQ_MASK reads 0 and ignores writes.
  - No mask flops are synthesised.

Decomposition:
- Package io_hub_pkg: address offset localparams (OFS_SW .. OFS_IRQ_MASK) and the BLINK_CTRL field positions.
- Sub-module btn_debounce (parameter DEB_CYCLES): one synchroniser + counter + level flop + rise pulse; instantiated NUM_BTN times via generate.

Test Plan:
- Reset release, then read all offsets 0x00..0x18 with switch=0 -> all return 0; led_out=0, blink_out=0, irq=0.
- DEB_CYCLES=4: button[2] held high for 3 cycles then low -> BTN_LEVEL stays 0, EVENT stays 0. Held for 10 cycles -> BTN_LEVEL bit2=1 and EVENT=0x4 exactly 6 cycles after the edge.
- Write 0x4 to 0x08 in the same cycle that button[0] rises through debounce -> EVENT reads 0x1 afterwards (set wins, bit2 cleared).
- Write LED=0xA5A5A5, then BLINK_CTRL enable=1, half-period 3 -> blink_out toggles every 3 cycles; led_out alternates between 0 and 0xA5A5A5.
- Write 0x1234 to 0x1C and 0x0F to 0x00 -> ignored; reads of 0x1C return 0. Assert reset mid-blink -> all outputs 0 immediately, without waiting for a clock edge.
- With IO_HUB_IRQ_EN: IRQ_MASK=0x2, trigger button[1] -> irq=1 one cycle after EVENT bit1 sets. W1C 0x2 -> irq falls one cycle later. Without the macro -> irq stays 0.

Source files
------------

// File: rtl/io_hub_pkg.sv
// Shared definitions for the io_hub memory-mapped I/O controller:
// register byte offsets inside the I/O window and BLINK_CTRL field positions.
package io_hub_pkg;

    localparam logic [4:0] OFS_SW         = 5'h00;
    localparam logic [4:0] OFS_BTN_LEVEL  = 5'h04;
    localparam logic [4:0] OFS_BTN_EVENT  = 5'h08;
    localparam logic [4:0] OFS_LED        = 5'h0C;
    localparam logic [4:0] OFS_SEG        = 5'h10;
    localparam logic [4:0] OFS_BLINK_CTRL = 5'h14;
    localparam logic [4:0] OFS_IRQ_MASK   = 5'h18;

    // BLINK_CTRL layout: enable in bit 0, half-period starting at bit 1.
    localparam int unsigned BLINK_EN_BIT  = 0;
    localparam int unsigned BLINK_PER_LSB = 1;

endpackage

// File: rtl/io_hub_btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced
// level flop and a single-cycle pulse on the 0->1 transition of the level.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 200000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip;

    // Count consecutive cycles the synced input disagrees with the level.
    always_comb begin
        flip    = 1'b0;
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                flip    = 1'b1;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, counter and level registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = flip & ~level_q;

endmodule

// File: rtl/io_hub.sv
// io_hub: memory-mapped switch/button/LED/segment/blink controller.
// Optional event interrupt and IRQ_MASK register enabled by IO_HUB_IRQ_EN.
module io_hub
    import io_hub_pkg::*;
#(
    parameter int unsigned NUM_BTN    = 4,
    parameter int unsigned SW_W       = 24,
    parameter int unsigned LED_W      = 24,
    parameter int unsigned SEG_W      = 32,
    parameter int unsigned DEB_CYCLES = 200000,
    parameter int unsigned BLINK_W    = 24
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_rd,
    input  logic               io_wr,
    input  logic [4:0]         io_addr,
    input  logic [31:0]        io_wdata,
    output logic [31:0]        io_rdata,
    input  logic [SW_W-1:0]    switch,
    input  logic [NUM_BTN-1:0] button,
    output logic [LED_W-1:0]   led_out,
    output logic [SEG_W-1:0]   seg_data,
    output logic               blink_out,
    output logic               irq
);

    localparam logic [2:0] W_SW    = OFS_SW[4:2];
    localparam logic [2:0] W_LEVEL = OFS_BTN_LEVEL[4:2];
    localparam logic [2:0] W_EVENT = OFS_BTN_EVENT[4:2];
    localparam logic [2:0] W_LED   = OFS_LED[4:2];
    localparam logic [2:0] W_SEG   = OFS_SEG[4:2];
    localparam logic [2:0] W_BLINK = OFS_BLINK_CTRL[4:2];
    localparam logic [2:0] W_MASK  = OFS_IRQ_MASK[4:2];

    logic [2:0]         word;
    logic               unused;
    logic [SW_W-1:0]    sw_sync1_q, sw_sync2_q;
    logic [NUM_BTN-1:0] btn_level, btn_rise;
    logic [NUM_BTN-1:0] event_q, event_d, ev_clr;
    logic [LED_W-1:0]   led_q;
    logic [SEG_W-1:0]   seg_q;
    logic               blink_en_q;
    logic [BLINK_W-1:0] blink_per_q;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;
    logic               blink_q, blink_d;
    logic [31:0]        mask_rd;
    logic               wr_event, wr_led, wr_seg, wr_blink;

    assign word   = io_addr[4:2];
    assign unused = ^{io_addr[1:0], io_wdata};

    assign wr_event = io_wr && (word == W_EVENT);
    assign wr_led   = io_wr && (word == W_LED);
    assign wr_seg   = io_wr && (word == W_SEG);
    assign wr_blink = io_wr && (word == W_BLINK);

    // Switch synchroniser.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= switch;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clock   (clock),
                .reset   (reset),
                .btn_i   (button[g]),
                .level_o (btn_level[g]),
                .rise_o  (btn_rise[g])
            );
        end
    endgenerate

    // Sticky event flags: W1C clear, a same-cycle rise takes priority.
    always_comb begin
        ev_clr  = wr_event ? io_wdata[NUM_BTN-1:0] : '0;
        event_d = (event_q & ~ev_clr) | btn_rise;
    end

    // Blink divider: counts 0..P-1, toggles the phase on wrap.
    always_comb begin
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        if (wr_blink) begin
            bcnt_d  = '0;
            blink_d = io_wdata[BLINK_EN_BIT] ? blink_q : 1'b0;
        end else if (!blink_en_q || (blink_per_q == '0)) begin
            bcnt_d  = '0;
            blink_d = 1'b0;
        end else if (bcnt_q == (blink_per_q - BLINK_W'(1))) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end else begin
            bcnt_d = bcnt_q + BLINK_W'(1);
        end
    end

    // CPU-writable registers, event flags and blink state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            event_q     <= '0;
            led_q       <= '0;
            seg_q       <= '0;
            blink_en_q  <= 1'b0;
            blink_per_q <= '0;
            bcnt_q      <= '0;
            blink_q     <= 1'b0;
        end else begin
            event_q <= event_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
            if (wr_led) led_q <= io_wdata[LED_W-1:0];
            if (wr_seg) seg_q <= io_wdata[SEG_W-1:0];
            if (wr_blink) begin
                blink_en_q  <= io_wdata[BLINK_EN_BIT];
                blink_per_q <= io_wdata[BLINK_PER_LSB +: BLINK_W];
            end
        end
    end

`ifdef IO_HUB_IRQ_EN
    logic [NUM_BTN-1:0] mask_q;
    logic               irq_q;
    logic               wr_mask;

    assign wr_mask = io_wr && (word == W_MASK);

    // Interrupt mask and registered interrupt request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_mask) mask_q <= io_wdata[NUM_BTN-1:0];
            irq_q <= |(event_q & mask_q);
        end
    end

    assign irq     = irq_q;
    assign mask_rd = 32'(mask_q);
`else
    assign irq     = 1'b0;
    assign mask_rd = '0;
`endif

    // Read mux, zero when no read strobe or unmapped offset.
    always_comb begin
        io_rdata = '0;
        if (io_rd) begin
            case (word)
                W_SW:    io_rdata = 32'(sw_sync2_q);
                W_LEVEL: io_rdata = 32'(btn_level);
                W_EVENT: io_rdata = 32'(event_q);
                W_LED:   io_rdata = 32'(led_q);
                W_SEG:   io_rdata = 32'(seg_q);
                W_BLINK: io_rdata = 32'({blink_per_q, blink_en_q});
                W_MASK:  io_rdata = mask_rd;
                default: io_rdata = '0;
            endcase
        end
    end

    assign led_out   = led_q & ~{LED_W{blink_en_q & ~blink_q}};
    assign seg_data  = seg_q;
    assign blink_out = blink_q;

endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: directed literal checks plus randomized
// traffic compared every cycle against a history-based behavioural model.
module tb_io_hub;

    localparam int NB  = 4;
    localparam int SWW = 24;
    localparam int LW  = 24;
    localparam int SGW = 32;
    localparam int DEB = 4;
    localparam int BW  = 24;
    localparam int HN  = 8192;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           io_rd, io_wr;
    logic [4:0]     io_addr;
    logic [31:0]    io_wdata, io_rdata;
    logic [SWW-1:0] switch;
    logic [NB-1:0]  button;
    logic [LW-1:0]  led_out;
    logic [SGW-1:0] seg_data;
    logic           blink_out, irq;

    always #5 clock = ~clock;

    io_hub #(
        .NUM_BTN(NB), .SW_W(SWW), .LED_W(LW), .SEG_W(SGW),
        .DEB_CYCLES(DEB), .BLINK_W(BW)
    ) dut (
        .clock(clock), .reset(reset), .io_rd(io_rd), .io_wr(io_wr),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .switch(switch), .button(button), .led_out(led_out),
        .seg_data(seg_data), .blink_out(blink_out), .irq(irq)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             cyc;
    logic [NB-1:0]  bh [0:HN-1];
    logic [SWW-1:0] swh [0:HN-1];
    logic [SWW-1:0] m_sw;
    logic [NB-1:0]  m_lev, m_ev, m_mask, m_rise, m_clr, m_r;
    logic           m_irq;
    logic [LW-1:0]  m_led;
    logic [SGW-1:0] m_seg;
    int             lastflip [NB];
    bit             m_en, m_base, m_bl, m_all;
    int             m_p, m_w;
    logic [4:0]     m_a;

    function automatic logic [NB-1:0] raw_btn(input int k);
        return (k < 1) ? '0 : bh[k % HN];
    endfunction

    function automatic logic [SWW-1:0] raw_sw(input int k);
        return (k < 1) ? '0 : swh[k % HN];
    endfunction

    function automatic logic [31:0] mrd(input logic [4:0] addr);
        case (addr & 5'h1C)
            5'h00: return 32'(m_sw);
            5'h04: return 32'(m_lev);
            5'h08: return 32'(m_ev);
            5'h0C: return 32'(m_led);
            5'h10: return 32'(m_seg);
            5'h14: return 32'({m_p[BW-1:0], m_en});
`ifdef IO_HUB_IRQ_EN
            5'h18: return 32'(m_mask);
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [LW-1:0] m_led_out();
        return (m_en && !m_bl) ? '0 : m_led;
    endfunction

    // Level flips once the delayed raw input has disagreed with it for DEB
    // consecutive samples since its previous flip.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc = 0; m_sw = '0; m_lev = '0; m_ev = '0; m_mask = '0; m_irq = 1'b0;
            m_led = '0; m_seg = '0; m_en = 1'b0; m_p = 0; m_w = 0;
            m_base = 1'b0; m_bl = 1'b0;
            for (int i = 0; i < NB; i++) lastflip[i] = 0;
        end else begin
            cyc++;
            bh[cyc % HN]  = button;
            swh[cyc % HN] = switch;
            m_sw = raw_sw(cyc - 1);
`ifdef IO_HUB_IRQ_EN
            m_irq = |(m_ev & m_mask);
`endif
            m_rise = '0;
            for (int i = 0; i < NB; i++) begin
                if (cyc - lastflip[i] >= DEB) begin
                    m_all = 1'b1;
                    for (int j = 0; j < DEB; j++) begin
                        m_r = raw_btn(cyc - 2 - j);
                        if (m_r[i] == m_lev[i]) m_all = 1'b0;
                    end
                    if (m_all) begin
                        m_lev[i] = ~m_lev[i];
                        lastflip[i] = cyc;
                        if (m_lev[i]) m_rise[i] = 1'b1;
                    end
                end
            end
            m_clr = '0;
            m_a = io_addr & 5'h1C;
            if (io_wr) begin
                case (m_a)
                    5'h08: m_clr = io_wdata[NB-1:0];
                    5'h0C: m_led = io_wdata[LW-1:0];
                    5'h10: m_seg = io_wdata[SGW-1:0];
`ifdef IO_HUB_IRQ_EN
                    5'h18: m_mask = io_wdata[NB-1:0];
`endif
                    default: ;
                endcase
            end
            m_ev = (m_ev & ~m_clr) | m_rise;
            if (io_wr && m_a == 5'h14) begin
                m_en   = io_wdata[0];
                m_p    = int'(io_wdata[BW:1]);
                m_base = m_en ? m_bl : 1'b0;
                m_w    = cyc;
                m_bl   = m_base;
            end else if (m_en && m_p != 0) begin
                m_bl = m_base ^ ((((cyc - m_w) / m_p) % 2) == 1);
            end else begin
                m_bl = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        check("rdata", io_rdata, io_rd ? mrd(io_addr) : 32'h0);
        check("led_out", 32'(led_out), 32'(m_led_out()));
        check("seg_data", seg_data, m_seg);
        check("blink_out", 32'(blink_out), 32'(m_bl));
        check("irq", 32'(irq), 32'(m_irq));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] v);
        io_rd = 1'b1;
        io_addr = a;
        #1;
        v = io_rdata;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        io_wr = 1'b1;
        io_addr = a;
        io_wdata = d;
        @(posedge clock);
        #1;
        io_wr = 1'b0;
    endtask

    logic [31:0] v;
    int k;

    initial begin
        io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_wdata = '0;
        switch = '0; button = '0; reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        for (int a = 0; a <= 24; a += 4) begin
            peek(5'(a), v);
            check("reset_read", v, 32'h0);
            step();
        end
        check("reset_led", 32'(led_out), 32'h0);
        check("reset_blink", 32'(blink_out), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);

        // 3-cycle glitch must be rejected
        button[2] = 1'b1;
        repeat (3) step();
        button[2] = 1'b0;
        repeat (10) step();
        peek(5'h04, v); check("glitch_level", v, 32'h0);
        peek(5'h08, v); check("glitch_event", v, 32'h0);

        // clean press: level and event appear 6 edges later
        step();
        button[2] = 1'b1;
        repeat (5) step();
        peek(5'h04, v); check("deb_level_early", v, 32'h0);
        step();
        peek(5'h04, v); check("deb_level", v, 32'h4);
        peek(5'h08, v); check("deb_event", v, 32'h4);
        repeat (4) step();
        button[2] = 1'b0;
        repeat (8) step();
        peek(5'h04, v); check("deb_fall", v, 32'h0);
        peek(5'h08, v); check("event_sticky", v, 32'h4);

        // W1C on the edge where button[0] is accepted: set wins
        button[0] = 1'b1;
        repeat (5) step();
        wr(5'h08, 32'h5);
        peek(5'h08, v); check("set_wins", v, 32'h1);
        peek(5'h04, v); check("level_b0", v, 32'h1);

        // interrupt path
        wr(5'h18, 32'h2);
        peek(5'h18, v);
`ifdef IO_HUB_IRQ_EN
        check("mask_read", v, 32'h2);
`else
        check("mask_read", v, 32'h0);
`endif
        button[1] = 1'b1;
        repeat (6) step();
        peek(5'h08, v); check("irq_event", v, 32'h3);
        check("irq_pre", 32'(irq), 32'h0);
        step();
`ifdef IO_HUB_IRQ_EN
        check("irq_set", 32'(irq), 32'h1);
        wr(5'h08, 32'h2);
        check("irq_hold", 32'(irq), 32'h1);
        step();
        check("irq_clear", 32'(irq), 32'h0);
`else
        check("irq_off", 32'(irq), 32'h0);
        wr(5'h08, 32'h2);
        step();
`endif
        peek(5'h08, v); check("event_after_w1c", v, 32'h1);
        button = '0;

        // blink, half-period 3
        wr(5'h0C, 32'h00A5A5A5);
        wr(5'h14, 32'h7);
        check("blink_w0", 32'(blink_out), 32'h0);
        check("led_w0", 32'(led_out), 32'h0);
        repeat (2) step();
        check("blink_t2", 32'(blink_out), 32'h0);
        step();
        check("blink_t3", 32'(blink_out), 32'h1);
        check("led_t3", 32'(led_out), 32'h00A5A5A5);
        repeat (3) step();
        check("blink_t6", 32'(blink_out), 32'h0);
        check("led_t6", 32'(led_out), 32'h0);
        peek(5'h14, v); check("blink_ctrl_read", v, 32'h7);

        // unmapped and read-only writes are ignored
        wr(5'h1C, 32'h1234);
        wr(5'h00, 32'h0F);
        peek(5'h1C, v); check("unmapped_read", v, 32'h0);
        peek(5'h1F, v); check("unmapped_read_b", v, 32'h0);
        peek(5'h0E, v); check("led_low_bits_ignored", v, 32'h00A5A5A5);
        step();
        peek(5'h00, v); check("sw_ro", v, 32'h0);
        wr(5'h10, 32'h12345678);
        peek(5'h10, v); check("seg_read", v, 32'h12345678);

        // asynchronous reset mid-blink
        k = 0;
        while (blink_out !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("blink_wait", 32'(blink_out), 32'h1);
        check("led_before_rst", 32'(led_out), 32'h00A5A5A5);
        #1 reset = 1'b0;
        #1;
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_seg", seg_data, 32'h0);
        check("rst_blink", 32'(blink_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        peek(5'h10, v); check("rst_seg_read", v, 32'h0);
        step();
        reset = 1'b1;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            io_wr   = ($urandom_range(0, 3) == 0);
            io_rd   = ($urandom_range(0, 2) != 0);
            io_addr = 5'($urandom_range(0, 31));
            io_wdata = $urandom;
            if (io_addr[4:2] == 3'd5)
                io_wdata = 32'(($urandom_range(0, 5) << 1) | $urandom_range(0, 1));
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 7) == 0) button[b] = ~button[b];
            if ($urandom_range(0, 15) == 0) switch = SWW'($urandom);
        end

        io_wr = 1'b0;
        io_rd = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
